lsu_dmem_ctrl: RTL
==================

Name: lsu_dmem_ctrl

Overview:
- Load/store unit between the core's memory stage and the word-only data memory.
- Accepts byte, halfword and word requests over a valid/ready handshake.
- Sign- or zero-extends load data.
- Performs read-modify-write for sub-word stores, because the data memory only writes whole words.
- Returns one response pulse per request.

Parameters:
- ADDR_W, 32, width of the request address and the data-memory address.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 decoded as word
- req_unsigned  in  1  zero-extend the load result
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  single-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores
- resp_err  out  1  misaligned access (feature-dependent)
- dmem_MemRead  out  1  data-memory read enable
- dmem_MemWrite  out  1  data-memory write enable
- dmem_addr  out  ADDR_W  word-aligned address, low 2 bits always 00
- dmem_wdata  out  32  full word to write
- dmem_rdata  in  32  combinational read data from the data memory

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state IDLE; req_ready=1 once rst deasserts; all other outputs 0; internal latches cleared.
- States: IDLE, LD, RMW_RD, ST_WR, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch we, size, unsigned, addr, wdata.
  - Next state: load -> LD; word store -> ST_WR; sub-word store -> RMW_RD; misaligned with trap -> RESP with err set.
- LD:
  - dmem_MemRead=1, dmem_addr={addr[ADDR_W-1:2],2'b00}.
  - Extract lane by addr[1:0] (byte) or addr[1] (half), extend, register into the result.
  - Next state: RESP.
- RMW_RD:
  - dmem_MemRead=1.
  - Merge the stored lane of req_wdata into dmem_rdata and register it as the write buffer.
  - Next state: ST_WR.
- ST_WR:
  - dmem_MemWrite=1, dmem_wdata = write buffer (word store: latched wdata).
  - Next state: RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; no backpressure; req_ready=0.
  - Next state: IDLE.
- req_ready=0 in every state except IDLE; one request in flight at most.
- Latency from the accept edge to resp_valid:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - trapped misalign: 1 cycle
- dmem_MemRead and dmem_MemWrite are never both high in the same cycle.
- dmem_addr, dmem_wdata and both enables are 0 outside the states that drive them.
- resp_rdata and resp_err are held only while resp_valid=1; they are 0 otherwise.
- Byte/halfword lanes are little-endian: byte k is bits [8k+7:8k].
- Back-to-back requests: a new request may be accepted in the IDLE cycle directly after RESP. An RMW read sees the previous write because the data memory write completes on the ST_WR edge.
- Reset mid-operation:
  - Immediate abort; enables drop asynchronously; no response is issued.
  - A write whose edge coincides with rst assertion is not guaranteed to land.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Misaligned means a half access with addr[0]=1, or a word access with addr[1:0]!=0.
- Defined:
  - A misaligned request performs no data-memory access.
  - RESP follows after 1 cycle with resp_err=1 and resp_rdata=0.
- Undefined:
  - Low address bits are ignored: half uses addr[1] only; word uses addr[1:0]=00.
  - resp_err is tied to 0.

Decomposition:
- Package lsu_pkg holds:
  - enum lsu_size_e (BYTE, HALF, WORD)
  - enum lsu_state_e
  - functions lsu_extract(word, off, size, unsigned) and lsu_merge(word, wdata, off, size)
- One sub-module, lsu_byte_lane: combinational extract/merge datapath instantiated by lsu_dmem_ctrl. All state lives in the top.

Test Plan:
- Preload the data-memory word at 0x10 = 0x8070_F0AA.
  - LB at 0x10 -> resp_rdata=0xFFFF_FFAA, 2 cycles after accept.
  - LBU at 0x11 -> 0x0000_00F0.
- LH at 0x12 -> 0xFFFF_8070; LHU at 0x12 -> 0x0000_8070.
- SB 0x55 at 0x13:
  - cycle 1: MemRead=1, addr 0x10
  - cycle 2: MemWrite=1, wdata 0x5570_F0AA
  - cycle 3: resp_valid
  - A following LW at 0x10 returns 0x5570_F0AA.
- SW 0xDEAD_BEEF at 0x20:
  - cycle 1: MemWrite=1, no MemRead
  - cycle 2: resp_valid
  - req_ready=0 on cycles 1-2 while req_valid is held high.
- LW at 0x12:
  - With LSU_MISALIGN_TRAP_EN: no MemRead; resp_err=1 and rdata=0 at cycle 1.
  - Without: MemRead at addr 0x10; rdata 0x8070_F0AA; err=0.
- SH at 0x10, then assert rst during RMW_RD:
  - MemWrite is never asserted and no resp_valid is issued.
  - After release: req_ready=1; the word at 0x10 is unchanged by this unit.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and lane extract/merge helpers for the load/store unit.
//   lsu_size_e  : request size encoding (11 is treated as WORD by callers)
//   lsu_state_e : controller states
//   lsu_extract : pick and sign/zero-extend a byte/half/word from a memory word
//   lsu_merge   : splice the store lane of wdata into a memory word
package lsu_pkg;
    typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10} lsu_size_e;
    typedef enum logic [2:0] {IDLE, LD, RMW_RD, ST_WR, RESP} lsu_state_e;
    // bit offset of the addressed lane; halves only look at off[1]
    function automatic logic [4:0] lsu_shift(logic [1:0] off, logic [1:0] size);
        return size[1] ? 5'd0 : (size == HALF) ? {off[1], 4'b0000} : {off, 3'b000};
    endfunction
    function automatic logic [31:0] lsu_extract(logic [31:0] word, logic [1:0] off, logic [1:0] size, logic uns);
        logic [31:0] v;
        v = word >> lsu_shift(off, size);
        return size[1] ? word :
               (size == HALF) ? {{16{~uns & v[15]}}, v[15:0]} : {{24{~uns & v[7]}}, v[7:0]};
    endfunction
    function automatic logic [31:0] lsu_merge(logic [31:0] word, logic [31:0] wdata, logic [1:0] off, logic [1:0] size);
        logic [4:0]  sh;
        logic [31:0] m;
        sh = lsu_shift(off, size);
        m  = (size[1] ? 32'hFFFF_FFFF : (size == HALF) ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
        return (word & ~m) | ((wdata << sh) & m);
    endfunction
endpackage

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: combinational load-extract / store-merge datapath.
//   i_rdata    : word read from data memory
//   i_wdata    : right-aligned store data
//   i_off      : byte address offset addr[1:0]
//   i_size     : access size (00 byte, 01 half, 1x word)
//   i_unsigned : zero-extend loads
//   o_ext      : extended load result
//   o_merged   : i_rdata with the store lane replaced
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_ext,
    output logic [31:0] o_merged
);
    assign o_ext    = lsu_extract(i_rdata, i_off, i_size, i_unsigned);
    assign o_merged = lsu_merge(i_rdata, i_wdata, i_off, i_size);
endmodule

// File: rtl/lsu_dmem_ctrl.sv
// lsu_dmem_ctrl: load/store unit between the memory stage and a word-only data memory.
//   core side : req_valid/req_ready handshake, req_we, req_size, req_unsigned,
//               req_addr, req_wdata; one-cycle resp_valid with resp_rdata/resp_err
//   memory    : dmem_MemRead, dmem_MemWrite, dmem_addr (word aligned), dmem_wdata,
//               dmem_rdata (combinational read data)
//   Sub-word stores are done as read-modify-write of the whole word.
//   Define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses with resp_err.
module lsu_dmem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              dmem_MemRead,
    output logic              dmem_MemWrite,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata
);
    lsu_state_e        r_state, w_next;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wbuf, r_result, w_ext, w_merged;
    logic              w_accept, w_misalign;

    assign w_accept = req_valid && req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_err;
    assign w_misalign = (req_size == HALF && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);
    assign resp_err   = (r_state == RESP) && r_err;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_err <= 1'b0;
        else if (w_accept) r_err <= w_misalign;
    end
`else
    assign w_misalign = 1'b0;
    assign resp_err   = 1'b0;
`endif

    lsu_byte_lane u_lane (
        .i_rdata   (dmem_rdata),
        .i_wdata   (r_wbuf),
        .i_off     (r_addr[1:0]),
        .i_size    (r_size),
        .i_unsigned(r_uns),
        .o_ext     (w_ext),
        .o_merged  (w_merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (w_accept) w_next = w_misalign ? RESP : !req_we ? LD : req_size[1] ? ST_WR : RMW_RD;
            LD, ST_WR: w_next = RESP;
            RMW_RD:    w_next = ST_WR;
            default:   w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready     = (r_state == IDLE) && !rst;
        dmem_MemRead  = (r_state == LD) || (r_state == RMW_RD);
        dmem_MemWrite = (r_state == ST_WR);
        dmem_addr     = (dmem_MemRead || dmem_MemWrite) ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
        dmem_wdata    = dmem_MemWrite ? r_wbuf : '0;
        resp_valid    = (r_state == RESP);
        resp_rdata    = resp_valid ? r_result : '0;
    end

    // r_wbuf holds the store data from accept, then the merged word after the RMW read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_size   <= '0;
            r_uns    <= 1'b0;
            r_addr   <= '0;
            r_wbuf   <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_size   <= req_size;
            r_uns    <= req_unsigned;
            r_addr   <= req_addr;
            r_wbuf   <= req_wdata;
            r_result <= '0;
        end else if (r_state == LD) begin
            r_result <= w_ext;
        end else if (r_state == RMW_RD) begin
            r_wbuf <= w_merged;
        end
    end
endmodule
